// File: rtl/app_pmem_reader.sv
// app_pmem_reader: radio-side read-back port for the app program memory.
// Prefetches one pmem word at a time into DATA and keeps a running checksum.
module app_pmem_reader #(
    parameter logic [14:0] BASE_ADDR = 15'h00B0,
    parameter int          DEC_WD    = 4,
    parameter int          PMEM_AW   = 12
) (
    input  logic               mclk,
    input  logic               puc_rst,
    input  logic [13:0]        per_addr,
    input  logic [15:0]        per_din,
    input  logic               per_en,
    input  logic [1:0]         per_we,
    output logic [15:0]        per_dout,
    output logic               app_reset_n,
    output logic [PMEM_AW-1:0] app_pmem_addr,
    output logic               app_pmem_cen,
    input  logic [15:0]        app_pmem_din,
    output logic               rd_active
);

    // Byte offsets of the registers inside the decoded block
    localparam logic [DEC_WD-1:0] CTRL_OFS = DEC_WD'(0);
    localparam logic [DEC_WD-1:0] STAT_OFS = DEC_WD'(2);
    localparam logic [DEC_WD-1:0] ADDR_OFS = DEC_WD'(4);
    localparam logic [DEC_WD-1:0] DATA_OFS = DEC_WD'(6);
    localparam logic [DEC_WD-1:0] CSUM_OFS = DEC_WD'(8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               reg_sel;
    logic [DEC_WD-1:0]  reg_ofs;
    logic               reg_wr;
    logic               reg_rd;
    logic               sel_ctrl;
    logic               sel_stat;
    logic               sel_addr;
    logic               sel_data;
    logic               sel_csum;

    logic               ctrl_wr;
    logic               stat_wr;
    logic               addr_wr;
    logic               data_rd;

    logic               en;
    logic [15:2]        ctrl_hi;
    logic               valid;
    logic               wrap;
    logic               underrun;
    logic [PMEM_AW-1:0] ptr;
    logic [15:0]        data_buf;
    logic [15:0]        csum;

    logic               en_rise;
    logic               en_fall;
    logic               csum_clr;
    logic               capture;
    logic               step;
    logic               reload;
    logic               busy;
    logic               cen;
    logic [15:0]        csum_base;
    logic [PMEM_AW-1:0] ptr_inc;

    // Peripheral bus decode (word address against the byte-aligned base)
    assign reg_sel = per_en &
                     (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_ofs = {per_addr[DEC_WD-2:0], 1'b0};
    assign reg_wr  = reg_sel & (|per_we);
    assign reg_rd  = reg_sel & ~(|per_we);

    assign sel_ctrl = (reg_ofs == CTRL_OFS);
    assign sel_stat = (reg_ofs == STAT_OFS);
    assign sel_addr = (reg_ofs == ADDR_OFS);
    assign sel_data = (reg_ofs == DATA_OFS);
    assign sel_csum = (reg_ofs == CSUM_OFS);

    assign ctrl_wr = reg_wr & sel_ctrl;
    assign stat_wr = reg_wr & sel_stat;
    assign addr_wr = reg_wr & sel_addr;
    assign data_rd = reg_rd & sel_data;

    // Control events
    assign en_rise  = ctrl_wr &  per_din[0] & ~en;
    assign en_fall  = ctrl_wr & ~per_din[0] &  en;
    assign csum_clr = ctrl_wr &  per_din[1];

    // A capture is dropped when the enable falls on the same edge
    assign capture = (state == S_CAPTURE) & ~en_fall;
    assign step    = (state == S_HOLD) & data_rd & valid;
    assign reload  = addr_wr & ((state == S_IDLE) | (state == S_HOLD));

    assign ptr_inc   = ptr + 1'b1;
    assign csum_base = csum_clr ? 16'h0000 : csum;

    // FSM state register
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: disable overrides every other transition
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (en_rise) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD:    if (step | reload) state_nxt = S_FETCH;
            default:   state_nxt = S_IDLE;
        endcase
        if (en_fall) begin
            state_nxt = S_IDLE;
        end
    end

    // FSM outputs: single-cycle chip enable and busy flag
    always_comb begin
        cen  = 1'b1;
        busy = 1'b0;
        unique case (state)
            S_FETCH: begin
                cen  = 1'b0;
                busy = 1'b1;
            end
            S_CAPTURE: busy = 1'b1;
            default: begin
                cen  = 1'b1;
                busy = 1'b0;
            end
        endcase
    end

    // CTRL: enable bit plus scratch bits; CSUM_CLR is never stored
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            en      <= 1'b0;
            ctrl_hi <= '0;
        end else if (ctrl_wr) begin
            en      <= per_din[0];
            ctrl_hi <= per_din[15:2];
        end
    end

    // Address pointer: loaded when idle or holding, stepped on DATA reads
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ptr <= '0;
        end else if (reload) begin
            ptr <= per_din[PMEM_AW-1:0];
        end else if (step) begin
            ptr <= ptr_inc;
        end
    end

    // VALID: set by a capture, cleared by consume, reload, enable or disable
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            valid <= 1'b0;
        end else if (en_fall | en_rise) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end else if (step | (reload & (state == S_HOLD))) begin
            valid <= 1'b0;
        end
    end

    // WRAP: sticky once the pointer steps past all-ones; cleared on enable
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wrap <= 1'b0;
        end else if (en_rise) begin
            wrap <= 1'b0;
        end else if (step & (&ptr)) begin
            wrap <= 1'b1;
        end
    end

    // UNDERRUN: DATA read with nothing buffered; write 1 to clear
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            underrun <= 1'b0;
        end else if (data_rd & ~valid) begin
            underrun <= 1'b1;
        end else if (stat_wr & per_din[3]) begin
            underrun <= 1'b0;
        end
    end

    // Data buffer takes the pmem word on the capture cycle
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            data_buf <= '0;
        end else if (capture) begin
            data_buf <= app_pmem_din;
        end
    end

    // Checksum: clear on enable, clear-then-add when both hit together
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            csum <= '0;
        end else if (en_rise) begin
            csum <= '0;
        end else if (capture) begin
            csum <= csum_base + app_pmem_din;
        end else if (csum_clr) begin
            csum <= '0;
        end
    end

    // Register read mux; zero whenever the block is not being read
    always_comb begin
        per_dout = '0;
        if (reg_rd) begin
            unique case (1'b1)
                sel_ctrl: per_dout = {ctrl_hi, 1'b0, en};
                sel_stat: per_dout = {12'h000, underrun, wrap, busy, valid};
                sel_addr: per_dout = {{(16-PMEM_AW){1'b0}}, ptr};
                sel_data: per_dout = data_buf;
                sel_csum: per_dout = csum;
                default:  per_dout = '0;
            endcase
        end
    end

    assign app_reset_n   = ~en;
    assign rd_active     = en;
    assign app_pmem_addr = ptr;
    assign app_pmem_cen  = cen;

endmodule

// File: tb/tb_app_pmem_reader.sv
// tb_app_pmem_reader: scoreboard bench for the pmem read-back peripheral.
// Directed corner cases followed by randomized read/reload/clear traffic.
module tb_app_pmem_reader;

    localparam logic [13:0] BASEW  = 14'h0058;
    localparam logic [2:0]  R_CTRL = 3'd0;
    localparam logic [2:0]  R_STAT = 3'd1;
    localparam logic [2:0]  R_ADDR = 3'd2;
    localparam logic [2:0]  R_DATA = 3'd3;
    localparam logic [2:0]  R_CSUM = 3'd4;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = '0;
    logic [15:0] per_dout;
    logic        app_reset_n;
    logic [11:0] app_pmem_addr;
    logic        app_pmem_cen;
    logic [15:0] app_pmem_din = '0;
    logic        rd_active;

    always #5 mclk = ~mclk;

    app_pmem_reader dut (
        .mclk          (mclk),
        .puc_rst       (puc_rst),
        .per_addr      (per_addr),
        .per_din       (per_din),
        .per_en        (per_en),
        .per_we        (per_we),
        .per_dout      (per_dout),
        .app_reset_n   (app_reset_n),
        .app_pmem_addr (app_pmem_addr),
        .app_pmem_cen  (app_pmem_cen),
        .app_pmem_din  (app_pmem_din),
        .rd_active     (rd_active)
    );

    // Synchronous-read program memory
    logic [15:0] mem [0:4095];
    always @(posedge mclk) begin
        if (!app_pmem_cen) app_pmem_din <= mem[app_pmem_addr];
    end

    int total = 0;
    int bad = 0;
    int cen_cnt = 0;
    logic [15:0] exp_q[$];
    string       name_q[$];
    logic [11:0] fa_q[$];
    logic        chk_rd = 1'b0;

    // Reference model state
    logic        m_en;
    logic [13:0] m_hi;
    int          m_ptr;
    logic [15:0] m_csum;
    logic        m_wrap;
    logic        m_und;
    logic [15:0] m_buf;
    logic        m_valid;
    logic        m_pend;

    // Monitor: checks scoreboarded reads and logs every fetch strobe
    always @(negedge mclk) begin : mon
        logic [15:0] e;
        string n;
        if (per_en && per_we == 2'b00 && chk_rd) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty got=%h want=none", per_dout);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (per_dout !== e) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", n, per_dout, e);
                end
            end
        end
        if (app_pmem_cen === 1'b0) begin
            cen_cnt++;
            fa_q.push_back(app_pmem_addr);
        end
    end

    task automatic chk(input string n, input logic [15:0] got,
                       input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    task automatic bus_wr(input logic [2:0] r, input logic [15:0] d);
        per_addr = BASEW + 14'(r);
        per_din  = d;
        per_we   = 2'b11;
        per_en   = 1'b1;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic bus_rd(input logic [2:0] r, input logic [15:0] want,
                          input string n);
        exp_q.push_back(want);
        name_q.push_back(n);
        per_addr = BASEW + 14'(r);
        per_we   = 2'b00;
        per_en   = 1'b1;
        chk_rd   = 1'b1;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        chk_rd = 1'b0;
    endtask

    function automatic logic [15:0] x_ctrl();
        return {m_hi, 1'b0, m_en};
    endfunction

    function automatic logic [15:0] x_stat();
        return {12'h000, m_und, m_wrap, 1'b0, m_valid};
    endfunction

    function automatic logic [15:0] x_addr();
        return 16'(m_ptr);
    endfunction

    task automatic m_reset();
        m_en = 0; m_hi = '0; m_ptr = 0; m_csum = '0; m_wrap = 0;
        m_und = 0; m_buf = '0; m_valid = 0; m_pend = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // Poll STAT until a word is buffered, then account for its capture
    task automatic wait_valid();
        logic [15:0] s;
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            per_addr = BASEW + 14'(R_STAT);
            per_we   = 2'b00;
            per_en   = 1'b1;
            @(negedge mclk);
            s = per_dout;
            @(posedge mclk);
            #1;
            per_en = 1'b0;
            ok = s[0];
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL valid_timeout got=0 want=1");
        end else if (m_pend) begin
            m_buf   = mem[m_ptr];
            m_csum  = m_csum + m_buf;
            m_valid = 1;
            m_pend  = 0;
        end
    endtask

    task automatic t_enable(input int a);
        bus_wr(R_ADDR, 16'(a));
        m_ptr = a;
        bus_wr(R_CTRL, {m_hi, 1'b0, 1'b1});
        m_en = 1; m_csum = '0; m_valid = 0; m_wrap = 0; m_pend = 1;
    endtask

    task automatic t_disable();
        bus_wr(R_CTRL, {m_hi, 1'b0, 1'b0});
        m_en = 0; m_valid = 0; m_pend = 0;
        chk("dis_app_reset_n", 16'(app_reset_n), 16'd1);
    endtask

    task automatic t_data(input string n);
        bus_rd(R_DATA, m_buf, n);
        if (m_valid) begin
            m_ptr = (m_ptr + 1) % 4096;
            if (m_ptr == 0) m_wrap = 1;
            m_valid = 0;
            m_pend  = 1;
        end else begin
            m_und = 1;
        end
    endtask

    task automatic t_addr_hold(input int a);
        bus_wr(R_ADDR, 16'(a));
        m_ptr = a; m_valid = 0; m_pend = 1;
    endtask

    initial begin : wd
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0;
        int op;
        logic [13:0] nh;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        m_reset();

        // Reset values
        #12;
        chk("rst_dout", per_dout, 16'h0000);
        chk("rst_app_reset_n", 16'(app_reset_n), 16'd1);
        chk("rst_cen", 16'(app_pmem_cen), 16'd1);
        chk("rst_pmem_addr", 16'(app_pmem_addr), 16'h0000);
        chk("rst_rd_active", 16'(rd_active), 16'd0);
        @(negedge mclk);
        puc_rst = 1'b0;
        idle(1);
        bus_rd(R_CTRL, 16'h0000, "rst_ctrl");
        bus_rd(R_STAT, 16'h0000, "rst_stat");
        bus_rd(R_ADDR, 16'h0000, "rst_addr");
        bus_rd(R_DATA, 16'h0000, "rst_data");
        m_und = 1;
        bus_rd(R_CSUM, 16'h0000, "rst_csum");
        bus_wr(R_STAT, 16'h0008);
        m_und = 0;

        // Sequential dump of four words
        mem[0] = 16'h1111; mem[1] = 16'h2222;
        mem[2] = 16'h3333; mem[3] = 16'h4444; mem[4] = 16'h0000;
        c0 = cen_cnt;
        t_enable(0);
        chk("t1_rd_active", 16'(rd_active), 16'd1);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            t_data("t1_data");
            chk("t1_app_reset_n", 16'(app_reset_n), 16'd0);
            wait_valid();
        end
        bus_rd(R_CSUM, 16'hAAAA, "t1_csum");
        chk("t1_cen_pulses", 16'(cen_cnt - c0), 16'd5);
        t_disable();

        // Underrun right after enable
        t_enable(16'h10);
        t_data("t2_underrun_data");
        wait_valid();
        bus_rd(R_STAT, x_stat(), "t2_stat_und");
        bus_rd(R_CSUM, m_csum, "t2_csum");
        bus_wr(R_STAT, 16'h0008);
        m_und = 0;
        bus_rd(R_STAT, x_stat(), "t2_stat_clr");
        t_disable();

        // Pointer wrap
        mem[12'hFFF] = 16'hBEEF; mem[0] = 16'h0001; mem[1] = 16'h0000;
        t_enable(12'hFFF);
        wait_valid();
        t_data("t3_data_fff");
        wait_valid();
        t_data("t3_data_000");
        wait_valid();
        bus_rd(R_STAT, x_stat(), "t3_stat_wrap");
        bus_rd(R_CSUM, 16'hBEF0, "t3_csum");
        t_disable();

        // Disable on the capture edge
        mem[16'h30] = 16'h1234;
        c0 = cen_cnt;
        t_enable(16'h30);
        idle(1);
        t_disable();
        idle(10);
        chk("t4_cen_pulses", 16'(cen_cnt - c0), 16'd1);
        bus_rd(R_STAT, x_stat(), "t4_stat");
        bus_rd(R_CSUM, m_csum, "t4_csum");
        bus_rd(R_ADDR, x_addr(), "t4_addr");

        // Reload pointer while holding, then clear-with-capture
        mem[16'h21] = 16'h5A5A;
        t_enable(5);
        wait_valid();
        fa_q.delete();
        t_addr_hold(16'h20);
        wait_valid();
        chk("t5_fetch_addr", fa_q.size() > 0 ? 16'(fa_q[0]) : 16'hFFFF,
            16'h0020);
        bus_rd(R_ADDR, 16'h0020, "t5_addr");
        t_data("t5_data");
        idle(1);
        bus_wr(R_CTRL, {m_hi, 1'b1, 1'b1});
        m_csum = '0;
        wait_valid();
        bus_rd(R_CSUM, m_csum, "t5_clr_capture_csum");
        bus_rd(R_CTRL, x_ctrl(), "t5_ctrl");

        // Asynchronous reset in the fetch cycle
        t_disable();
        t_enable(16'h40);
        puc_rst = 1'b1;
        #1;
        chk("t6_cen", 16'(app_pmem_cen), 16'd1);
        chk("t6_app_reset_n", 16'(app_reset_n), 16'd1);
        chk("t6_rd_active", 16'(rd_active), 16'd0);
        chk("t6_pmem_addr", 16'(app_pmem_addr), 16'h0000);
        @(negedge mclk);
        puc_rst = 1'b0;
        idle(1);
        m_reset();
        bus_rd(R_CTRL, x_ctrl(), "t6_ctrl");
        bus_rd(R_STAT, x_stat(), "t6_stat");
        bus_rd(R_ADDR, x_addr(), "t6_addr");
        bus_rd(R_CSUM, m_csum, "t6_csum");

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            m_hi = 14'($urandom);
            if ($urandom_range(0, 2) == 0) t_enable(4095 - $urandom_range(0, 3));
            else t_enable($urandom_range(0, 4095));
            wait_valid();
            for (int k = 0; k < 25; k++) begin
                idle($urandom_range(0, 2));
                op = $urandom_range(0, 9);
                if (op <= 4) begin
                    t_data("rnd_data");
                    wait_valid();
                end else if (op == 5) begin
                    t_data("rnd_data");
                    t_data("rnd_stale_data");
                    wait_valid();
                    bus_rd(R_STAT, x_stat(), "rnd_stat_und");
                    bus_wr(R_STAT, 16'h0008);
                    m_und = 0;
                end else if (op == 6) begin
                    t_addr_hold($urandom_range(0, 4095));
                    wait_valid();
                end else if (op == 7) begin
                    nh = 14'($urandom);
                    bus_wr(R_CTRL, {nh, 1'b1, 1'b1});
                    m_hi = nh;
                    m_csum = '0;
                end else if (op == 8) begin
                    bus_rd(R_CSUM, m_csum, "rnd_csum");
                end else begin
                    bus_rd(R_STAT, x_stat(), "rnd_stat");
                    bus_rd(R_ADDR, x_addr(), "rnd_addr");
                    bus_rd(R_CTRL, x_ctrl(), "rnd_ctrl");
                end
            end
            bus_rd(R_CSUM, m_csum, "rnd_end_csum");
            bus_rd(R_STAT, x_stat(), "rnd_end_stat");
            t_disable();
            bus_rd(R_CTRL, x_ctrl(), "rnd_end_ctrl");
        end

        idle(2);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
